// File: rtl/pair_reader.sv
// pair_reader: walks a range of even/odd word pairs in a dual-port RAM,
// issues a synchronous read on both ports, and serializes each returned pair
// (port A word, then port B word) onto a valid/ready stream.
module pair_reader #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int START_PAIR = 512,
  parameter int END_PAIR   = 640
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] FIRST_PAIR = PAIR_W'(START_PAIR);
  localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(END_PAIR - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_SEND_A,
    S_SEND_B,
    S_FIN
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [PAIR_W-1:0]   pair;
  logic [PAIR_W-1:0]   pair_nx;
  logic [DATA_W-1:0]   hold_b;
  logic [DATA_W-1:0]   out_data_nx;
  logic                rd_en_nx;
  logic                out_valid_nx;
  logic                busy_nx;
  logic                done_nx;

  // Both RAM addresses are pure wiring from the pair register, so they hold
  // their last value whenever the pair register is not advancing.
  assign addr_a = {pair, 1'b0};
  assign addr_b = {pair, 1'b1};

  // Next-state, pair and stream-data decisions; every output is then derived
  // from the next state so that it can be registered without a combinational
  // path from start or out_ready.
  always_comb begin
    state_nx     = state;
    pair_nx      = pair;
    out_data_nx  = out_data;
    rd_en_nx     = 1'b0;
    out_valid_nx = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_READ;
          pair_nx  = FIRST_PAIR;
        end
      end
      S_READ: begin
        state_nx = S_CAPT;
      end
      S_CAPT: begin
        // The out_data register doubles as the A holding register: the A
        // word goes straight onto the stream while B waits in hold_b.
        state_nx    = S_SEND_A;
        out_data_nx = q_a;
      end
      S_SEND_A: begin
        if (out_ready) begin
          state_nx    = S_SEND_B;
          out_data_nx = hold_b;
        end
      end
      S_SEND_B: begin
        if (out_ready) begin
          if (pair == LAST_PAIR) begin
            state_nx = S_FIN;
          end else begin
            state_nx = S_READ;
            pair_nx  = pair + PAIR_W'(1);
          end
        end
      end
      S_FIN: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    rd_en_nx     = (state_nx == S_READ);
    out_valid_nx = (state_nx == S_SEND_A) || (state_nx == S_SEND_B);
    busy_nx      = (state_nx == S_READ) || (state_nx == S_CAPT) ||
                   (state_nx == S_SEND_A) || (state_nx == S_SEND_B);
    done_nx      = (state_nx == S_FIN);
  end

  // State, pair index and registered outputs; reset drops any partial pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pair      <= FIRST_PAIR;
      rd_en     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      pair      <= pair_nx;
      rd_en     <= rd_en_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  // Port B word is parked here during the capture cycle until A is accepted.
  always_ff @(posedge clk) begin
    if (state == S_CAPT) begin
      hold_b <= q_b;
    end
  end

endmodule

// File: tb/tb_pair_reader.sv
// tb_pair_reader: randomized bench for pair_reader with a RAM model and a
// reference expectation built from the pair range and the RAM contents.
module tb_pair_reader;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int SP = 512;
  localparam int EP = 640;

  logic          clk;
  logic          reset;
  logic          start;
  logic          rd_en;
  logic [AW-1:0] addr_a;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] q_a;
  logic [DW-1:0] q_b;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  logic          s_start;
  logic          s_rd_en;
  logic [AW-1:0] s_addr_a;
  logic [AW-1:0] s_addr_b;
  logic [DW-1:0] s_q_a;
  logic [DW-1:0] s_q_b;
  logic [DW-1:0] s_out_data;
  logic          s_out_valid;
  logic          s_busy;
  logic          s_done;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            rmode;

  int            n_checks;
  int            n_errors;

  logic [DW-1:0] got_q [$];
  int            rd_cnt, done_cnt, stab_bad, addr_bad;
  logic          pv, pr;
  logic [DW-1:0] pd;

  logic [DW-1:0] s_got [$];
  int            s_rd_cnt, s_done_cnt;

  pair_reader #(.ADDR_W(AW), .DATA_W(DW), .START_PAIR(SP), .END_PAIR(EP)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_en(rd_en),
    .addr_a(addr_a), .addr_b(addr_b), .q_a(q_a), .q_b(q_b),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  pair_reader #(.ADDR_W(AW), .DATA_W(DW), .START_PAIR(5), .END_PAIR(6)) dut_small (
    .clk(clk), .reset(reset), .start(s_start), .rd_en(s_rd_en),
    .addr_a(s_addr_a), .addr_b(s_addr_b), .q_a(s_q_a), .q_b(s_q_b),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(1'b1),
    .busy(s_busy), .done(s_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dual-port RAM model; unread cycles return noise.
  always @(posedge clk) begin
    if (rd_en) begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end else begin
      q_a <= DW'($urandom);
      q_b <= DW'($urandom);
    end
    if (s_rd_en) begin
      s_q_a <= mem[s_addr_a];
      s_q_b <= mem[s_addr_b];
    end else begin
      s_q_a <= DW'($urandom);
      s_q_b <= DW'($urandom);
    end
  end

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Stream observer: collects accepted words and tallies protocol events.
  always @(negedge clk) begin
    if (!reset) begin
      pv <= 1'b0;
      pr <= 1'b1;
    end else begin
      if (rd_en) begin
        rd_cnt <= rd_cnt + 1;
        if (addr_a[0] || (addr_b != addr_a + AW'(1))) addr_bad <= addr_bad + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (pv && !pr && (!out_valid || out_data != pd)) stab_bad <= stab_bad + 1;
      pv <= out_valid;
      pr <= out_ready;
      pd <= out_data;
      if (s_rd_en) s_rd_cnt <= s_rd_cnt + 1;
      if (s_done) s_done_cnt <= s_done_cnt + 1;
      if (s_out_valid) s_got.push_back(s_out_data);
    end
  end

  initial begin
    rd_cnt = 0; done_cnt = 0; stab_bad = 0; addr_bad = 0;
    s_rd_cnt = 0; s_done_cnt = 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < (1 << AW); i++) mem[i] = rnd ? DW'($urandom) : DW'(i);
  endtask

  // Called just after a rising edge: raise start for one cycle, then check
  // the first READ cycle.
  task automatic start_pass(input string tag);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_rd_en1"}, rd_en, 1);
    chk({tag, "_addr_a1"}, addr_a, 2 * SP);
    chk({tag, "_addr_b1"}, addr_b, 2 * SP + 1);
    chk({tag, "_busy1"}, busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget, input bit poke);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        if (poke) start = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, ok, 1);
    if (poke) begin
      @(posedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic check_pass(input string tag, input int qb, input int qe,
                            input int rb, input int re, input int db, input int de);
    int nbad;
    int k;
    logic [DW-1:0] e;
    nbad = 0;
    k = 0;
    chk({tag, "_nwords"}, qe - qb, 2 * (EP - SP));
    for (int p = SP; p < EP; p++) begin
      for (int h = 0; h < 2; h++) begin
        e = mem[2 * p + h];
        if (qb + k >= qe || got_q[qb + k] !== e) nbad++;
        k++;
      end
    end
    chk({tag, "_words_bad"}, nbad, 0);
    if (qe > qb) chk({tag, "_first"}, got_q[qb], mem[2 * SP]);
    chk({tag, "_rd_count"}, re - rb, EP - SP);
    chk({tag, "_done_count"}, de - db, 1);
  endtask

  initial begin
    int qb, rb, db, qm, rm, dm, lat, sq, sr, sd;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    start = 1'b0;
    s_start = 1'b0;
    rmode = 0;
    fill_mem(1'b0);

    // reset state
    #12;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr_a", addr_a, 2 * SP);
    chk("rst_addr_b", addr_b, 2 * SP + 1);
    chk("rst_s_addr_a", s_addr_a, 10);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy, 0);

    // basic pass, identity RAM, always ready
    @(posedge clk);
    qb = got_q.size(); rb = rd_cnt; db = done_cnt;
    start_pass("basic");
    wait_done("basic", 3000, 1'b0);
    chk("basic_busy_at_done", busy, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("basic_busy_after", busy, 0);
    check_pass("basic", qb, got_q.size(), rb, rd_cnt, db, done_cnt);

    // backpressure: stall the first A word, then random ready
    rmode = 2;
    @(posedge clk);
    qb = got_q.size(); rb = rd_cnt; db = done_cnt;
    start_pass("bp");
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_data", out_data, 2 * SP);
      if (i < 4) @(negedge clk);
    end
    rmode = 1;
    wait_done("bp", 5000, 1'b0);
    repeat (5) @(posedge clk);
    check_pass("bp", qb, got_q.size(), rb, rd_cnt, db, done_cnt);

    // ignored start at pair 530 and during the FIN cycle, random data
    fill_mem(1'b1);
    @(posedge clk);
    qb = got_q.size(); rb = rd_cnt; db = done_cnt;
    start_pass("ign");
    lat = 0;
    while (!(rd_en && addr_a == AW'(2 * 530)) && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_reach_530", rd_en, 1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("ign", 5000, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("ign_busy_after", busy, 0);
    check_pass("ign", qb, got_q.size(), rb, rd_cnt, db, done_cnt);

    // mid-pass reset during SEND_B of pair 600
    fill_mem(1'b0);
    rmode = 0;
    @(posedge clk);
    start_pass("mid");
    lat = 0;
    while (!(out_valid && out_data == DW'(2 * 600 + 1)) && lat < 3000) begin
      @(negedge clk);
      lat++;
    end
    chk("mid_reach_600b", out_data, 2 * 600 + 1);
    reset = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_rd_en", rd_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_addr_a", addr_a, 2 * SP);
    chk("mid_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    rb = rd_cnt;
    repeat (6) @(negedge clk);
    chk("mid_stays_idle", rd_cnt - rb, 0);
    chk("mid_idle_busy", busy, 0);
    fill_mem(1'b1);
    rmode = 1;
    @(posedge clk);
    qb = got_q.size(); rb = rd_cnt; db = done_cnt;
    start_pass("mid2");
    wait_done("mid2", 5000, 1'b0);
    repeat (5) @(posedge clk);
    check_pass("mid2", qb, got_q.size(), rb, rd_cnt, db, done_cnt);

    // back-to-back passes
    rmode = 0;
    @(posedge clk);
    qb = got_q.size(); rb = rd_cnt; db = done_cnt;
    start_pass("b2b_1");
    wait_done("b2b_1", 3000, 1'b0);
    @(posedge clk);
    qm = got_q.size(); rm = rd_cnt; dm = done_cnt;
    start_pass("b2b_2");
    wait_done("b2b_2", 3000, 1'b0);
    repeat (5) @(posedge clk);
    check_pass("b2b_1", qb, qm, rb, rm, db, dm);
    check_pass("b2b_2", qm, got_q.size(), rm, rd_cnt, dm, done_cnt);

    // small range START_PAIR=5, END_PAIR=6
    @(posedge clk);
    sq = s_got.size(); sr = s_rd_cnt; sd = s_done_cnt;
    #1 s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    lat = 1;
    @(negedge clk);
    chk("small_rd_en1", s_rd_en, 1);
    chk("small_addr_a", s_addr_a, 10);
    chk("small_addr_b", s_addr_b, 11);
    chk("small_busy1", s_busy, 1);
    while (!s_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("small_latency", lat, 3);
    chk("small_first_data", s_out_data, mem[10]);
    lat = 0;
    while (!s_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("small_done_seen", s_done, 1);
    chk("small_busy_at_done", s_busy, 0);
    repeat (4) @(negedge clk);
    chk("small_nwords", s_got.size() - sq, 2);
    if (s_got.size() >= sq + 2) begin
      chk("small_word0", s_got[sq], mem[10]);
      chk("small_word1", s_got[sq + 1], mem[11]);
    end
    chk("small_rd_count", s_rd_cnt - sr, 1);
    chk("small_done_count", s_done_cnt - sd, 1);

    chk("stream_stable", stab_bad, 0);
    chk("addr_pairing", addr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pair_reader.md
# pair_reader

Read-side counterpart of the draw path's paired address writer. The draw logic fills a dual-port pixel RAM two words at a time, with an even address on port A and the adjacent odd address on port B. `pair_reader` walks the same pair range, issues synchronous reads on both ports, and serializes each returned pair (A word first, then B word) onto a valid/ready stream for the display or scan-out logic.

## Interface
Parameters:
- `ADDR_W`, default 14: RAM word-address width. The pair index is `ADDR_W-1` bits.
- `DATA_W`, default 16: RAM word width.
- `START_PAIR`, default 512: first pair index read. Must be less than `END_PAIR`.
- `END_PAIR`, default 640: exclusive end pair index. Default words read: 1024..1279.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low.
- `start`, in, 1: one-cycle request to begin a pass. Ignored while `busy`=1.
- `rd_en`, out, 1: read strobe for both RAM ports.
- `addr_a`, out, ADDR_W: port A address, `{pair, 1'b0}`.
- `addr_b`, out, ADDR_W: port B address, `{pair, 1'b1}`.
- `q_a`, in, DATA_W: port A read data. Valid one cycle after `rd_en`.
- `q_b`, in, DATA_W: port B read data. Valid one cycle after `rd_en`.
- `out_data`, out, DATA_W: stream data.
- `out_valid`, out, 1: stream valid.
- `out_ready`, in, 1: downstream ready.
- `busy`, out, 1: high from the cycle after `start` is accepted until the cycle `done` is asserted.
- `done`, out, 1: one-cycle pulse when the pass is complete.

## Operation
States:
- `IDLE`: `busy`=0. On `start`=1, load `pair`=START_PAIR and go to `READ`.
- `READ`: `rd_en`=1 for exactly one cycle, with addresses driven from `pair`. Next state is `CAPT`.
- `CAPT`: latch `q_a` into `hold_a` and `q_b` into `hold_b`. Next state is `SEND_A`.
- `SEND_A`: `out_valid`=1, `out_data`=`hold_a`. Leave on `out_ready`=1. Next state is `SEND_B`.
- `SEND_B`: `out_valid`=1, `out_data`=`hold_b`. Leave on `out_ready`=1.
  - If `pair`==END_PAIR-1, go to `FIN`.
  - Otherwise, `pair`<=`pair`+1 and go to `READ`.
- `FIN`: `done`=1 for one cycle. Next state is `IDLE`.

Rules:
- `addr_a` and `addr_b` always reflect `pair`. They hold their last value in `IDLE`.
- `pair` arithmetic is `ADDR_W-1` bits wide and unsigned. It never exceeds END_PAIR-1, so there is no wrap.
- A pass emits exactly 2*(END_PAIR-START_PAIR) words. The default is 256.
- Stream rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_valid` hold stable. `out_valid` never drops without a handshake.
- `out_data` holds its last sent value when `out_valid`=0.
- `start` during `busy` or during `FIN` is ignored. It is not queued.
- `rd_en` is never asserted outside `READ`.

Reset values, applied asynchronously whenever `reset`=0, including mid-pass:
- State `IDLE`, `pair`=START_PAIR.
- `addr_a`={START_PAIR,0}, `addr_b`={START_PAIR,1}.
- `rd_en`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0.
- Any partially sent pair is discarded. After reset deassertion, the block waits for a new `start`.

## Timing
- Cycle 0: `start`=1 sampled in `IDLE`.
- Cycle 1: `rd_en`=1, `addr_a`=1024, `addr_b`=1025 (default parameters), `busy`=1.
- Cycle 2: capture cycle. RAM data is sampled at the end of this cycle.
- Cycle 3: first `out_valid`=1 with word A.
- Minimum 4 cycles per pair with `out_ready` tied high. A full default pass takes 512 cycles from the `READ` of the first pair to the last B handshake.
- `done` is asserted the cycle after the final B handshake. `busy` falls in the same cycle. The earliest accepted new `start` is the cycle after `done`.
- All outputs are registered. There is no combinational path from `out_ready` or `start` to any output.

## Test plan
- **Basic pass:** default parameters, `out_ready`=1, RAM model returns data equal to the address. Pulse `start`. Expect:
  - 256 words 1024, 1025, …, 1279, in order;
  - `rd_en` asserted exactly 128 times;
  - a single `done` pulse, with `busy` low afterwards.
- **Backpressure:** hold `out_ready`=0 for 5 cycles on the first A word and toggle it randomly afterwards. Expect `out_data`=1024 stable through the stall, and the full sequence 1024..1279 with no loss or duplication.
- **Ignored start:** pulse `start` at pair 530 and during the `FIN` cycle. Expect no restart, exactly 256 words, and one `done`.
- **Mid-pass reset:** assert `reset`=0 while in `SEND_B` of pair 600. Expect immediately `out_valid`=0, `rd_en`=0, `busy`=0, `addr_a`=1024. A new `start` then produces a clean 1024..1279 pass.
- **Small range:** START_PAIR=5, END_PAIR=6. Expect exactly words 10 and 11, then `done`. Also check the first-word latency of 3 cycles after `start`.
- **Back-to-back passes:** issue `start` the cycle after `done`. Expect a second identical 256-word pass with no idle gap beyond the `IDLE` cycle.
